// File: rtl/branch_train_queue_pkg.sv
// Shared defaults and record layout for the branch training queue.
// A record is packed as {isbranch, taken, pc, target}, target in the low bits.
package branch_train_queue_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 32;

  function automatic int rec_w(input int aw);
    return 2 + 2 * aw;
  endfunction

  function automatic int off_target(input int aw);
    return 0 * aw;
  endfunction

  function automatic int off_pc(input int aw);
    return aw;
  endfunction

  function automatic int off_taken(input int aw);
    return 2 * aw;
  endfunction

  function automatic int off_isbranch(input int aw);
    return 2 * aw + 1;
  endfunction

endpackage

// File: rtl/branch_train_queue_storage.sv
// DEPTH x W register file with two write ports and two combinational read ports.
// Port 1 is applied after port 0, so it wins if both hit the same address.
module btq_storage #(
  parameter int DEPTH = 16,
  parameter int W     = 66
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [W-1:0]             wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [W-1:0]             wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [W-1:0]             rdata0,
  output logic [W-1:0]             rdata1
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; occupancy lives in the pointers,
  // so stale contents are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/branch_train_queue.sv
// Dual-in / dual-out in-order queue between retire and the gshare training ports.
// Pointers, occupancy and the registered training outputs live here.
module branch_train_queue
  import branch_train_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid0,
  input  logic                       in_valid1,
  input  logic                       in_isbranch0,
  input  logic                       in_isbranch1,
  input  logic                       in_taken0,
  input  logic                       in_taken1,
  input  logic [AW-1:0]              in_pc0,
  input  logic [AW-1:0]              in_pc1,
  input  logic [AW-1:0]              in_target0,
  input  logic [AW-1:0]              in_target1,
  output logic                       in_ready,
  input  logic                       drain_en,
  output logic                       train_valid0,
  output logic                       train_valid1,
  output logic                       isbranch0,
  output logic                       isbranch1,
  output logic                       taken0,
  output logic                       taken1,
  output logic [AW-1:0]              address_branch0,
  output logic [AW-1:0]              address_branch1,
  output logic [AW-1:0]              address_result0,
  output logic [AW-1:0]              address_result1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_overflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RW  = rec_w(AW);
  localparam int OTG = off_target(AW);
  localparam int OPC = off_pc(AW);
  localparam int OTK = off_taken(AW);
  localparam int OIB = off_isbranch(AW);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [1:0]    n_in, n_out;
  logic [RW-1:0] rec0, rec1, rdata0, rdata1;
  logic [PW-1:0] waddr1;

  assign count    = count_q;
  assign in_ready = count_q <= CW'(DEPTH - 2);
  assign n_in     = in_ready ? ({1'b0, in_valid0} + {1'b0, in_valid1}) : 2'd0;

  always_comb begin
    n_out = 2'd0;
    if (drain_en) n_out = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
  end

  assign rec0   = {in_isbranch0, in_taken0, in_pc0, in_target0};
  assign rec1   = {in_isbranch1, in_taken1, in_pc1, in_target1};
  // A lone slot-1 record takes the slot-0 position so the queue stays dense.
  assign waddr1 = in_valid0 ? wr_ptr + PW'(1) : wr_ptr;

  btq_storage #(.DEPTH(DEPTH), .W(RW)) u_storage (
    .clk    (clk),
    .we0    (in_ready & in_valid0),
    .waddr0 (wr_ptr),
    .wdata0 (rec0),
    .we1    (in_ready & in_valid1),
    .waddr1 (waddr1),
    .wdata1 (rec1),
    .raddr0 (rd_ptr),
    .raddr1 (rd_ptr + PW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // NOTE: all state here is sequential, so only non-blocking assignments are
  // used; every register reads pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      err_overflow    <= 1'b0;
      train_valid0    <= 1'b0;
      train_valid1    <= 1'b0;
      isbranch0       <= 1'b0;
      isbranch1       <= 1'b0;
      taken0          <= 1'b0;
      taken1          <= 1'b0;
      address_branch0 <= '0;
      address_branch1 <= '0;
      address_result0 <= '0;
      address_result1 <= '0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(n_in);
      rd_ptr       <= rd_ptr + PW'(n_out);
      count_q      <= count_q + CW'(n_in) - CW'(n_out);
      train_valid0 <= n_out != 2'd0;
      train_valid1 <= n_out == 2'd2;
      if (!in_ready && (in_valid0 || in_valid1)) err_overflow <= 1'b1;
      if (n_out != 2'd0) begin
        isbranch0       <= rdata0[OIB];
        taken0          <= rdata0[OTK];
        address_branch0 <= rdata0[OPC +: AW];
        address_result0 <= rdata0[OTG +: AW];
      end
      if (n_out == 2'd2) begin
        isbranch1       <= rdata1[OIB];
        taken1          <= rdata1[OTK];
        address_branch1 <= rdata1[OPC +: AW];
        address_result1 <= rdata1[OTG +: AW];
      end
    end
  end

endmodule

// File: tb/tb_branch_train_queue.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based model of the in-order training buffer.
module tb_branch_train_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 32;

  typedef struct packed {
    logic          isb;
    logic          tk;
    logic [AW-1:0] pc;
    logic [AW-1:0] tg;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid0, in_valid1, in_isbranch0, in_isbranch1, in_taken0, in_taken1;
  logic [AW-1:0] in_pc0, in_pc1, in_target0, in_target1;
  logic in_ready, drain_en;
  logic train_valid0, train_valid1, isbranch0, isbranch1, taken0, taken1;
  logic [AW-1:0] address_branch0, address_branch1, address_result0, address_result1;
  logic [$clog2(DEPTH):0] count;
  logic err_overflow;

  int checks = 0;
  int errors = 0;

  rec_t q[$];
  logic m_v0, m_v1, m_err;
  rec_t m_o0, m_o1;

  always #5 clk = ~clk;

  branch_train_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid0       (in_valid0),
    .in_valid1       (in_valid1),
    .in_isbranch0    (in_isbranch0),
    .in_isbranch1    (in_isbranch1),
    .in_taken0       (in_taken0),
    .in_taken1       (in_taken1),
    .in_pc0          (in_pc0),
    .in_pc1          (in_pc1),
    .in_target0      (in_target0),
    .in_target1      (in_target1),
    .in_ready        (in_ready),
    .drain_en        (drain_en),
    .train_valid0    (train_valid0),
    .train_valid1    (train_valid1),
    .isbranch0       (isbranch0),
    .isbranch1       (isbranch1),
    .taken0          (taken0),
    .taken1          (taken1),
    .address_branch0 (address_branch0),
    .address_branch1 (address_branch1),
    .address_result0 (address_result0),
    .address_result1 (address_result1),
    .count           (count),
    .err_overflow    (err_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one clock edge, using the inputs as presented.
  task automatic model_edge();
    int sz, n_out;
    bit ready;
    if (rst) begin
      q.delete();
      m_v0 = 0; m_v1 = 0; m_err = 0;
      m_o0 = '0; m_o1 = '0;
      return;
    end
    sz    = q.size();
    ready = (DEPTH - sz) >= 2;
    n_out = drain_en ? ((sz >= 2) ? 2 : sz) : 0;
    m_v0  = n_out >= 1;
    m_v1  = n_out == 2;
    if (n_out >= 1) m_o0 = q.pop_front();
    if (n_out == 2) m_o1 = q.pop_front();
    if (ready) begin
      if (in_valid0) q.push_back('{in_isbranch0, in_taken0, in_pc0, in_target0});
      if (in_valid1) q.push_back('{in_isbranch1, in_taken1, in_pc1, in_target1});
    end else if (in_valid0 || in_valid1) begin
      m_err = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("count", count, q.size());
    check("in_ready", in_ready, (DEPTH - q.size()) >= 2);
    check("err_overflow", err_overflow, m_err);
    check("train_valid0", train_valid0, m_v0);
    check("train_valid1", train_valid1, m_v1);
    check("slot0_rec", {isbranch0, taken0, address_branch0, address_result0}, m_o0);
    if (m_v1)
      check("slot1_rec", {isbranch1, taken1, address_branch1, address_result1}, m_o1);
  endtask

  task automatic idle_inputs();
    in_valid0 = 0; in_valid1 = 0;
    in_isbranch0 = 0; in_isbranch1 = 0; in_taken0 = 0; in_taken1 = 0;
    in_pc0 = '0; in_pc1 = '0; in_target0 = '0; in_target1 = '0;
  endtask

  task automatic put0(input bit v, input bit isb, input bit tk, input logic [AW-1:0] pc,
                      input logic [AW-1:0] tg);
    in_valid0 = v; in_isbranch0 = isb; in_taken0 = tk; in_pc0 = pc; in_target0 = tg;
  endtask

  task automatic put1(input bit v, input bit isb, input bit tk, input logic [AW-1:0] pc,
                      input logic [AW-1:0] tg);
    in_valid1 = v; in_isbranch1 = isb; in_taken1 = tk; in_pc1 = pc; in_target1 = tg;
  endtask

  task automatic do_reset();
    rst = 1; drain_en = 0; idle_inputs();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; drain_en = 0; idle_inputs();
    m_v0 = 0; m_v1 = 0; m_err = 0; m_o0 = '0; m_o1 = '0;

    // Single record: visible on the train port two edges after presentation.
    do_reset();
    put0(1, 1, 1, 32'h100, 32'h200);
    drain_en = 1;
    tick();
    idle_inputs();
    check("t1_not_yet", train_valid0, 1'b0);
    tick();
    check("t1_valid0", train_valid0, 1'b1);
    check("t1_valid1", train_valid1, 1'b0);
    check("t1_pc", address_branch0, 32'h100);
    check("t1_target", address_result0, 32'h200);
    check("t1_taken", taken0, 1'b1);
    tick();
    check("t1_count", count, 0);

    // Fill to DEPTH without draining, then overflow.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      put0(1, 1, i[0], 32'h1000 + 8 * i, $urandom());
      put1(1, 1, ~i[0], 32'h1004 + 8 * i, $urandom());
      tick();
    end
    check("t2_full_count", count, 16);
    check("t2_full_ready", in_ready, 1'b0);
    put0(1, 1, 0, 32'hdead, 32'h0);
    put1(1, 0, 0, 32'hbeef, 32'h0);
    tick();
    check("t2_err", err_overflow, 1'b1);
    check("t2_count_held", count, 16);

    // Full queue draining while producer pushes two per cycle, across wrap.
    drain_en = 1;
    for (int i = 0; i < 24; i++) begin
      put0(1, $urandom_range(0, 1), $urandom_range(0, 1), 32'h2000 + 8 * i, $urandom());
      put1(1, $urandom_range(0, 1), $urandom_range(0, 1), 32'h2004 + 8 * i, $urandom());
      tick();
    end

    // Lone slot 1, then a pair; then the 3-record drain pattern.
    do_reset();
    put1(1, 1, 0, 32'h40, 32'h400);
    tick();
    put0(1, 0, 0, 32'h44, 32'h440);
    put1(1, 1, 1, 32'h48, 32'h480);
    tick();
    idle_inputs();
    drain_en = 1;
    tick();
    check("t4_pair_v1", train_valid1, 1'b1);
    check("t4_pair_pc0", address_branch0, 32'h40);
    check("t4_pair_pc1", address_branch1, 32'h44);
    check("t4_nonbranch", isbranch1, 1'b0);
    check("t5_count1", count, 1);
    tick();
    check("t5_v0", train_valid0, 1'b1);
    check("t5_v1", train_valid1, 1'b0);
    check("t4_last_pc", address_branch0, 32'h48);

    // Reset with entries queued and training active.
    do_reset();
    drain_en = 0;
    for (int i = 0; i < 4; i++) begin
      put0(1, 1, 1, 32'h3000 + 8 * i, $urandom());
      put1(i < 3, 1, 0, 32'h3004 + 8 * i, $urandom());
      tick();
    end
    idle_inputs();
    drain_en = 1;
    tick();
    check("t6_pre_count", count, 5);
    check("t6_pre_v0", train_valid0, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_count", count, 0);
    check("t6_v0", train_valid0, 1'b0);
    check("t6_v1", train_valid1, 1'b0);
    check("t6_err", err_overflow, 1'b0);
    check("t6_ready", in_ready, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      drain_en = ($urandom_range(0, 3) != 0) ? (i[6] | $urandom_range(0, 1)) : 1'b0;
      put0($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom());
      put1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom());
      tick();
    end
    rst = 0; idle_inputs(); drain_en = 1;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
